// File: rtl/hdmi_timing_overlay_pkg.sv
// Shared constants and helpers for the HDMI timing generator and overlay compositor.
package hdmi_timing_overlay_pkg;

    // Overlay compositing modes; the spare encoding behaves like opaque.
    localparam logic [1:0] OVL_BYPASS = 2'd0;
    localparam logic [1:0] OVL_OPAQUE = 2'd1;
    localparam logic [1:0] OVL_KEY    = 2'd2;
    localparam logic [1:0] OVL_RSVD   = 2'd3;

    // Total length of one timing axis (pixels per line or lines per frame).
    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int h_total(input int act, input int fp, input int sync, input int bp);
        return axis_total(act, fp, sync, bp);
    endfunction

    function automatic int v_total(input int act, input int fp, input int sync, input int bp);
        return axis_total(act, fp, sync, bp);
    endfunction

endpackage

// File: rtl/hdmi_timing_overlay_core.sv
// video_timing_core: h/v counters, sync and data-enable decode, frame start pulse.
// The counters are exposed combinationally so the top level can decode the
// window on the same counter state; all pin-level outputs are registered.
module video_timing_core
    import hdmi_timing_overlay_pkg::*;
#(
    parameter int H_ACTIVE = 720,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 62,
    parameter int H_BP     = 60,
    parameter int V_ACTIVE = 1280,
    parameter int V_FP     = 9,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 30,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 12
) (
    input  logic          clock,
    input  logic          reset,
    output logic [CW-1:0] h_count,
    output logic [CW-1:0] v_count,
    output logic          active,
    output logic          origin,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic hsync_zone;
    logic vsync_zone;

    // Raster position: line and frame wrap together at the last pixel.
    always_ff @(posedge clock) begin
        if (reset) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_count == H_LAST) begin
            h_count <= '0;
            v_count <= (v_count == V_LAST) ? '0 : v_count + 1'b1;
        end else begin
            h_count <= h_count + 1'b1;
        end
    end

    // Zone decode of the current counter state.
    always_comb begin
        active     = (h_count < H_ACT) && (v_count < V_ACT);
        origin     = (h_count == '0) && (v_count == '0);
        hsync_zone = (h_count >= HS_START) && (h_count < HS_END);
        vsync_zone = (v_count >= VS_START) && (v_count < VS_END);
    end

    // Registered pin outputs, one cycle behind the counter state.
    always_ff @(posedge clock) begin
        if (reset) begin
            de          <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            de          <= active;
            hsync       <= hsync_zone ? HS_POL : ~HS_POL;
            vsync       <= vsync_zone ? VS_POL : ~VS_POL;
            frame_start <= origin;
        end
    end

endmodule

// File: rtl/hdmi_timing_overlay.sv
// HDMI timing generator with an overlay window composited onto a background.
// Stream handshake: a pixel transfers on a cycle where pixValid and pixReady
// are both high; pixReady depends only on the raster position (never on
// pixValid), so the producer may hold pixValid high and simply wait.
module hdmi_timing_overlay
    import hdmi_timing_overlay_pkg::*;
#(
    parameter int H_ACTIVE = 720,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 62,
    parameter int H_BP     = 60,
    parameter int V_ACTIVE = 1280,
    parameter int V_FP     = 9,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 30,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int CW       = 12
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [23:0]   bgColour,
    input  logic [CW-1:0] ovlX,
    input  logic [CW-1:0] ovlY,
    input  logic [CW-1:0] ovlW,
    input  logic [CW-1:0] ovlH,
    input  logic [1:0]    ovlMode,
    input  logic [23:0]   keyColour,
    input  logic [23:0]   pixData,
    input  logic          pixValid,
    output logic          pixReady,
    output logic          DE,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic [23:0]   data,
    output logic          frameStart,
    output logic          underflow,
    output logic [15:0]   underflowCount
);

    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic          active;
    logic          origin;

    logic [CW-1:0] shadow_x;
    logic [CW-1:0] shadow_y;
    logic [CW-1:0] shadow_w;
    logic [CW-1:0] shadow_h;
    logic [1:0]    shadow_mode;

    logic [CW:0]   x_end;
    logic [CW:0]   y_end;
    logic          in_win;
    logic          take;

    video_timing_core #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HS_POL   (HS_POL),   .VS_POL (VS_POL), .CW (CW)
    ) u_timing (
        .clock       (clock),
        .reset       (reset),
        .h_count     (h_count),
        .v_count     (v_count),
        .active      (active),
        .origin      (origin),
        .de          (DE),
        .hsync       (HSYNC),
        .vsync       (VSYNC),
        .frame_start (frameStart)
    );

    // Window geometry is frozen per frame: captured only at the raster origin.
    always_ff @(posedge clock) begin
        if (reset || origin) begin
            shadow_x    <= ovlX;
            shadow_y    <= ovlY;
            shadow_w    <= ovlW;
            shadow_h    <= ovlH;
            shadow_mode <= ovlMode;
        end
    end

    // Window compare in CW+1 bits so the far edge cannot wrap; gating with
    // active clips the window to the visible area.
    always_comb begin
        x_end  = {1'b0, shadow_x} + {1'b0, shadow_w};
        y_end  = {1'b0, shadow_y} + {1'b0, shadow_h};
        in_win = active
              && (shadow_mode != OVL_BYPASS)
              && (shadow_w != '0) && (shadow_h != '0)
              && ({1'b0, h_count} >= {1'b0, shadow_x}) && ({1'b0, h_count} < x_end)
              && ({1'b0, v_count} >= {1'b0, shadow_y}) && ({1'b0, v_count} < y_end);
        pixReady = in_win && !reset;
        take     = pixReady && pixValid;
    end

    // Output colour: blank, background, or overlay pixel (key colour shows background).
    always_ff @(posedge clock) begin
        if (reset) begin
            data <= '0;
        end else if (!active) begin
            data <= '0;
        end else if (!take) begin
            data <= bgColour;
        end else if ((shadow_mode == OVL_KEY) && (pixData == keyColour)) begin
            data <= bgColour;
        end else begin
            data <= pixData;
        end
    end

    // Sticky starvation flag and saturating count of starved window pixels.
    always_ff @(posedge clock) begin
        if (reset) begin
            underflow      <= 1'b0;
            underflowCount <= '0;
        end else if (in_win && !pixValid) begin
            underflow <= 1'b1;
            if (underflowCount != 16'hFFFF) begin
                underflowCount <= underflowCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_timing_overlay.sv
// Directed/random bench for hdmi_timing_overlay on a tiny 14x7 raster.
module tb_hdmi_timing_overlay;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int CW = 12;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic [23:0] BG  = 24'h102030;
    localparam logic [23:0] KEY = 24'hFF00FF;

    logic          clock = 1'b0;
    logic          reset;
    logic [23:0]   bgColour;
    logic [CW-1:0] ovlX, ovlY, ovlW, ovlH;
    logic [1:0]    ovlMode;
    logic [23:0]   keyColour;
    logic [23:0]   pixData;
    logic          pixValid;
    logic          pixReady;
    logic          DE, HSYNC, VSYNC;
    logic [23:0]   data;
    logic          frameStart;
    logic          underflow;
    logic [15:0]   underflowCount;

    hdmi_timing_overlay #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HS_POL (1'b1), .VS_POL (1'b1), .CW (CW)
    ) dut (
        .clock (clock), .reset (reset), .bgColour (bgColour),
        .ovlX (ovlX), .ovlY (ovlY), .ovlW (ovlW), .ovlH (ovlH),
        .ovlMode (ovlMode), .keyColour (keyColour),
        .pixData (pixData), .pixValid (pixValid), .pixReady (pixReady),
        .DE (DE), .HSYNC (HSYNC), .VSYNC (VSYNC), .data (data),
        .frameStart (frameStart), .underflow (underflow),
        .underflowCount (underflowCount)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state: t is the raster index since the last reset.
    int t, cyc, last_fs;
    int sx, sy, sw, sh, smode;
    int seq, win_k, rdy_cnt, de_cnt, uf_cnt;
    bit uf;
    int valid_policy, data_policy;
    logic [23:0] base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic step();
        int h, v;
        bit act, inw, fs;
        logic [23:0] ed;
        h   = t % HT;
        v   = (t / HT) % VT;
        act = (h < HA) && (v < VA);
        inw = act && smode != 0 && sw != 0 && sh != 0 &&
              h >= sx && h < sx + sw && v >= sy && v < sy + sh;
        fs  = (h == 0) && (v == 0);
        if (fs) win_k = 0;
        case (valid_policy)
            0:       pixValid = 1'b1;
            1:       pixValid = !(inw && (win_k == 1 || win_k == 4));
            default: pixValid = ($urandom_range(0, 3) != 0);
        endcase
        case (data_policy)
            0:       pixData = base + 24'(seq);
            1:       pixData = seq[0] ? KEY : base + 24'(seq);
            default: pixData = 24'($urandom);
        endcase
        @(negedge clock);
        check("pixReady", pixReady, inw);
        if (!act) ed = '0;
        else if (!inw) ed = bgColour;
        else if (pixValid) ed = (smode == 2 && pixData == keyColour) ? bgColour : pixData;
        else begin
            ed = bgColour;
            uf = 1'b1;
            if (uf_cnt < 65535) uf_cnt++;
        end
        @(posedge clock);
        #1;
        cyc++;
        check("DE", DE, act);
        check("HSYNC", HSYNC, (h >= HA + HF) && (h < HA + HF + HS));
        check("VSYNC", VSYNC, (v >= VA + VF) && (v < VA + VF + VS));
        check("data", data, ed);
        check("frameStart", frameStart, fs);
        check("underflow", underflow, uf);
        check("underflowCount", underflowCount, uf_cnt);
        if (fs) begin
            if (last_fs >= 0) check("fs_period", cyc - last_fs, FT);
            last_fs = cyc;
        end
        if (inw && pixValid) seq++;
        if (inw) begin win_k++; rdy_cnt++; end
        if (act) de_cnt++;
        if (fs) begin
            sx = ovlX; sy = ovlY; sw = ovlW; sh = ovlH; smode = ovlMode;
        end
        t++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check("rst_pixReady", pixReady, 1'b0);
            @(posedge clock);
            #1;
            check("rst_DE", DE, 1'b0);
            check("rst_HSYNC", HSYNC, 1'b0);
            check("rst_VSYNC", VSYNC, 1'b0);
            check("rst_data", data, 24'h0);
            check("rst_frameStart", frameStart, 1'b0);
            check("rst_underflow", underflow, 1'b0);
            check("rst_underflowCount", underflowCount, 16'h0);
        end
        sx = ovlX; sy = ovlY; sw = ovlW; sh = ovlH; smode = ovlMode;
        uf = 1'b0; uf_cnt = 0; t = 0; last_fs = -1; win_k = 0;
        reset = 1'b0;
    endtask

    task automatic run_frame();
        rdy_cnt = 0;
        de_cnt  = 0;
        repeat (FT) step();
    endtask

    task automatic set_win(input int x, input int y, input int w, input int hh, input int m);
        ovlX = CW'(x); ovlY = CW'(y); ovlW = CW'(w); ovlH = CW'(hh); ovlMode = 2'(m);
    endtask

    initial begin
        cyc = 0; seq = 0; base = 24'h0;
        valid_policy = 0; data_policy = 0;
        bgColour = BG; keyColour = KEY;
        pixData = '0; pixValid = 1'b0;
        set_win(0, 0, 0, 0, 0);

        // 1: bare timing over two frames.
        do_reset();
        run_frame();
        check("s1_de_cnt", de_cnt, 32);
        check("s1_rdy_cnt", rdy_cnt, 0);
        run_frame();
        check("s1_de_cnt2", de_cnt, 32);

        // 2: opaque window, incrementing stream from 0.
        set_win(2, 1, 3, 2, 1);
        seq = 0;
        run_frame();
        check("s2_rdy_cnt", rdy_cnt, 6);
        check("s2_seq", seq, 6);
        run_frame();
        check("s2_rdy_cnt2", rdy_cnt, 6);

        // 3: colour key on every other stream pixel.
        set_win(2, 1, 3, 2, 2);
        data_policy = 1;
        run_frame();
        check("s3_rdy_cnt", rdy_cnt, 6);

        // 4: two starved window pixels, then sticky through a clean frame.
        set_win(2, 1, 3, 2, 1);
        data_policy = 0;
        valid_policy = 1;
        run_frame();
        check("s4_uf_cnt", underflowCount, 16'd2);
        valid_policy = 0;
        run_frame();
        check("s4_uf_sticky", underflow, 1'b1);
        check("s4_uf_cnt_sticky", underflowCount, 16'd2);

        // Random windows, modes, data and valid gaps.
        valid_policy = 2;
        data_policy  = 2;
        repeat (4) begin
            keyColour = ($urandom_range(0, 1) != 0) ? KEY : 24'($urandom);
            set_win($urandom_range(0, 9), $urandom_range(0, 4), $urandom_range(0, 6),
                    $urandom_range(0, 4), $urandom_range(0, 3));
            run_frame();
        end
        keyColour = KEY;
        valid_policy = 0;
        data_policy  = 0;

        // 5: mid-frame X changes only take effect next frame; clipping at column 7.
        set_win(2, 1, 3, 2, 1);
        run_frame();
        rdy_cnt = 0;
        repeat (50) step();
        ovlX = CW'(5);
        repeat (FT - 50) step();
        check("s5_rdy_unchanged", rdy_cnt, 6);
        run_frame();
        check("s5_rdy_x5", rdy_cnt, 6);
        rdy_cnt = 0;
        repeat (50) step();
        ovlX = CW'(6);
        ovlW = CW'(5);
        repeat (FT - 50) step();
        check("s5_rdy_x5_again", rdy_cnt, 6);
        run_frame();
        check("s5_rdy_clip", rdy_cnt, 4);

        // 6: reset in the middle of line 2 at column 6.
        repeat (2 * HT + 6) step();
        check("s6_pre_uf", underflowCount != 16'd0, 1'b1);
        do_reset();
        run_frame();
        check("s6_uf_cnt", underflowCount, 16'd0);
        check("s6_de_cnt", de_cnt, 32);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hdmi_timing_overlay.md
Name: hdmi_timing_overlay

Overview:
- Parametrised successor to the fixed hsync/vsync/DE/dataWrite chain.
- A single block generates complete video timing (active, front porch, sync, back porch per axis) with configurable sync polarity.
- It composites an overlay window, fed by a ready/valid pixel stream from the DDR reader, onto a background colour.
- It drives the HDMI transmitter's DE, HSYNC, VSYNC and 24-bit data pins, and sits between the pixel clock generator and those pins.

Parameters:
- H_ACTIVE, 720, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 62, horizontal sync width (pixels)
- H_BP, 60, horizontal back porch (pixels)
- V_ACTIVE, 1280, visible lines per frame
- V_FP, 9, vertical front porch (lines)
- V_SYNC, 6, vertical sync width (lines)
- V_BP, 30, vertical back porch (lines)
- HS_POL, 1, HSYNC level during sync (1 = active-high)
- VS_POL, 1, VSYNC level during sync
- CW, 12, width of the h/v counters and overlay coordinates

Ports:
- clock  in  1  pixel clock
- reset  in  1  synchronous, active-high reset
- bgColour  in  24  background RGB
- ovlX  in  CW  overlay window left column
- ovlY  in  CW  overlay window top line
- ovlW  in  CW  overlay width (0 = window off)
- ovlH  in  CW  overlay height (0 = window off)
- ovlMode  in  2  0 = bypass, 1 = opaque, 2 = colour-key, 3 = reserved (treated as opaque)
- keyColour  in  24  transparent colour for mode 2
- pixData  in  24  overlay pixel stream data
- pixValid  in  1  stream valid
- pixReady  out  1  stream ready
- DE  out  1  data enable
- HSYNC  out  1  horizontal sync
- VSYNC  out  1  vertical sync
- data  out  24  RGB output
- frameStart  out  1  one-cycle pulse at hCount = 0, vCount = 0
- underflow  out  1  sticky: a window pixel was needed while pixValid was low
- underflowCount  out  16  saturating count of underflowed pixels

Behaviour:
Reset:
- hCount = vCount = 0; DE = 0; HSYNC = !HS_POL; VSYNC = !VS_POL; data = 0.
- frameStart = 0; underflow = 0; underflowCount = 0; pixReady = 0.
- Shadow registers load from the ovl* inputs and ovlMode.

Counters:
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL is defined the same way.
- hCount wraps at H_TOTAL-1 to 0 and increments vCount; vCount wraps at V_TOTAL-1 to 0.
- Reset mid-frame restarts at (0,0) on the next cycle.

Decode:
- active = hCount < H_ACTIVE && vCount < V_ACTIVE.
- hsyncZone = H_ACTIVE+H_FP ≤ hCount < H_ACTIVE+H_FP+H_SYNC; vsyncZone is the same form on vCount.
- VSYNC changes only at hCount = 0.

Latency:
- All outputs are registered, exactly 1 cycle after the counter state that produces them.
- frameStart is asserted the cycle after the counter holds (0,0).

Shadowing:
- ovlX, ovlY, ovlW, ovlH and ovlMode are sampled into shadow registers only when the counter holds (0,0).
- Mid-frame input changes are ignored until the next frame.

Window:
- inWin = active && shadowMode != 0 && shadowW != 0 && shadowH != 0 && ovlX ≤ hCount < ovlX+ovlW && ovlY ≤ vCount < ovlY+ovlH.
- Arithmetic is CW+1 bits so edges never wrap.
- The window is clipped to the active area.

Handshake:
- pixReady = inWin, combinational from the registered counters.
- A pixel is consumed when pixValid && pixReady.
- Outside the window pixReady = 0 and the stream stalls.

Data mux (registered):
- Not active: data = 0.
- Active, outside the window: data = bgColour.
- In the window with a pixel consumed: mode 2 with pixData == keyColour gives bgColour; otherwise data = pixData.
- In the window with pixValid = 0: data = bgColour, underflow is set, and underflowCount increments, saturating at 16'hFFFF.
- underflow and underflowCount clear only on reset.

Simultaneous events:
- Line wrap and frame wrap occur in the same cycle at (H_TOTAL-1, V_TOTAL-1).
- Shadow load and frameStart coincide.

Decomposition:
- Shared package: overlay mode constants (OVL_BYPASS, OVL_OPAQUE, OVL_KEY) and the total-width functions for H_TOTAL and V_TOTAL.
- Sub-module: video_timing_core holds the counters, sync/DE decode and frameStart.
- The top level adds shadowing, the window compare, the handshake, the data mux and the underflow logic.

Test Plan:
Bench parameters: H 8/2/2/2 (H_TOTAL = 14), V 4/1/1/1 (V_TOTAL = 7), polarities 1, bgColour = 0x102030.
1. Reset, then run 2 frames -> DE high for 8 of every 14 cycles on lines 0–3; HSYNC high at hCount 10–11; VSYNC high on line 5; frameStart period = 98 cycles.
2. Window X = 2, Y = 1, W = 3, H = 2, mode 1, pixValid = 1 with incrementing data -> pixReady high for exactly 6 cycles per frame; data shows values 0..5 at (2..4, 1..2); all other active pixels = 0x102030.
3. Mode 2, keyColour = 0xFF00FF, every other stream pixel = 0xFF00FF -> those positions output 0x102030 and the stream still advances.
4. Same window as scenario 2, pixValid low for 2 window cycles -> underflow = 1, underflowCount = 2, data = 0x102030 at those pixels, sticky through the next frame.
5. Change ovlX from 2 to 5 mid-frame -> current frame is unchanged; the next frame's window starts at column 5; X = 6 with W = 5 clips at column 7 (pixReady for 2 columns).
6. Assert reset at hCount = 6, vCount = 2 -> next cycle all outputs are at their reset values; after release, the first frameStart comes 1 cycle after the counter reaches (0,0), and underflowCount = 0.
